mult_stim_checker: RTL and testbench
====================================

MULT_STIM_CHECKER -- requirements
Module: mult_stim_checker

Interface
REQ-001 Parameter WIDTH, default 2, sets the operand width driven to the multiplier under test.
REQ-002 Parameter NUM_VECTORS, default 20, sets the vectors per run; the legal range is 1..65535.
REQ-003 Parameter SEED, default 16'hACE1, sets the LFSR start value; 16'h0000 SHALL be replaced by 16'hACE1.
REQ-004 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 Port rst: input, 1 bit, reset; synchronous and active-high.
REQ-006 Port start: input, 1 bit, run request, sampled only in IDLE or DONE.
REQ-007 Port A: output, WIDTH bits, operand A to the multiplier under test.
REQ-008 Port B: output, WIDTH bits, operand B to the multiplier under test.
REQ-009 Port P: input, 2*WIDTH bits, product returned by the combinational multiplier under test.
REQ-010 Port busy: output, 1 bit, high while a run is in progress.
REQ-011 Port done: output, 1 bit, high while in DONE.
REQ-012 Port pass_count: output, 16 bits, vectors whose product matched.
REQ-013 Port err_count: output, 16 bits, vectors whose product mismatched.
REQ-014 Port fail_info: output, 16+4*WIDTH bits, the first failing vector as {index, A, B, P}.

Function
REQ-015 The FSM SHALL have four states: IDLE, DRIVE, SAMPLE, DONE.
REQ-016 IDLE or DONE with start=1 SHALL transition to DRIVE, reload the LFSR with SEED, clear both counters and fail_info, and zero the vector index.
REQ-017 Any state other than IDLE or DONE SHALL ignore start.
REQ-018 In DRIVE, A SHALL be lfsr[WIDTH-1:0] and B SHALL be lfsr[2*WIDTH-1:WIDTH], both registered.
REQ-019 A and B SHALL stay constant through the following SAMPLE cycle.
REQ-020 DRIVE SHALL always be followed by SAMPLE after exactly one cycle.
REQ-021 On the edge leaving SAMPLE, P SHALL be compared with the full-width product A*B (2*WIDTH bits, unsigned).
REQ-022 On a match, pass_count SHALL increment; on a mismatch, err_count SHALL increment.
REQ-023 Both counters SHALL saturate at 16'hFFFF.
REQ-024 On leaving SAMPLE, the LFSR SHALL advance one step and the index SHALL increment.
REQ-025 The LFSR SHALL be a 16-bit Galois LFSR with polynomial x^16+x^14+x^13+x^11+1.
REQ-026 Leaving SAMPLE with index = NUM_VECTORS-1 SHALL go to DONE; otherwise it SHALL go to DRIVE.
REQ-027 In DONE, done=1, busy=0, and the counters SHALL hold until the next accepted start.
REQ-028 busy SHALL equal 1 exactly in DRIVE and SAMPLE.
REQ-029 done SHALL rise exactly 2*NUM_VECTORS rising edges after the edge that accepts start.

Reset
REQ-030 While rst=1 at a rising edge: state SHALL become IDLE and A, B, busy, done, pass_count, err_count and fail_info SHALL become 0.
REQ-031 While rst=1 at a rising edge, the LFSR SHALL load SEED.
REQ-032 rst SHALL take priority over start.
REQ-033 Reset mid-run SHALL abort the run with no done pulse.

Configuration
REQ-034 When MULT_CHK_FAILCAP_EN is defined, the first mismatch of a run SHALL latch {index, A, B, P} into fail_info.
REQ-035 The latched fail_info SHALL hold until the next start or reset.
REQ-036 When MULT_CHK_FAILCAP_EN is undefined, fail_info SHALL be constant 0 and no capture registers SHALL be built.

Verification
REQ-037 Scenario: defaults, correct 2-bit multiplier, start pulse -> first DRIVE shows A=1, B=0; done rises 40 edges later; pass_count=20; err_count=0.
REQ-038 Scenario: P tied to 4'hF -> every vector fails (maximum product is 9); err_count=20; pass_count=0; with MULT_CHK_FAILCAP_EN, fail_info index=0, A=1, B=0, P=4'hF.
REQ-039 Scenario: start re-pulsed 5 cycles into a run -> ignored; done still at 40 edges; counts unchanged versus REQ-037.
REQ-040 Scenario: rst=1 for one cycle at cycle 12 of a run -> next cycle all outputs are 0 and the state is IDLE; a subsequent start reproduces the REQ-037 results exactly.
REQ-041 Scenario: NUM_VECTORS=1 -> done after 2 edges; pass_count=1.
REQ-042 Scenario: start held high continuously with a correct multiplier -> a new run begins the cycle after each DONE; each run reports pass_count=20.

Source files
------------

// File: rtl/mult_stim_checker.sv
// Self-test stimulus generator and checker for a combinational WIDTH x WIDTH multiplier.
// Optional first-failure capture is built when MULT_CHK_FAILCAP_EN is defined.
module mult_stim_checker #(
    parameter int          WIDTH       = 2,
    parameter int          NUM_VECTORS = 20,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [WIDTH-1:0]       A,
    output logic [WIDTH-1:0]       B,
    input  logic [2*WIDTH-1:0]     P,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            pass_count,
    output logic [15:0]            err_count,
    output logic [16+4*WIDTH-1:0]  fail_info
);

    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [15:0] LAST_IDX  = 16'(NUM_VECTORS - 1);
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int          FAIL_W    = 16 + 4 * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] r;
        r = {1'b0, v[15:1]};
        if (v[0]) begin
            r = r ^ LFSR_TAPS;
        end else begin
            r = r;
        end
        return r;
    endfunction

    state_t               state_r;
    state_t               state_s;
    logic [15:0]          lfsr_r;
    logic [15:0]          lfsr_adv_s;
    logic [15:0]          idx_r;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic                 busy_r;
    logic                 done_r;
    logic [15:0]          pass_r;
    logic [15:0]          err_r;
    logic                 start_ok_s;
    logic [2*WIDTH-1:0]   product_s;
    logic                 match_s;

    assign lfsr_adv_s = lfsr_step(lfsr_r);
    assign product_s  = {{WIDTH{1'b0}}, a_r} * {{WIDTH{1'b0}}, b_r};
    assign match_s    = (P == product_s);

    // Next-state logic; start is only honoured from IDLE or DONE.
    always_comb begin
        state_s    = state_r;
        start_ok_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s    = ST_DRIVE;
                    start_ok_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                state_s = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (idx_r == LAST_IDX) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRIVE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_s    = ST_DRIVE;
                    start_ok_s = 1'b1;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, operand, LFSR and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            lfsr_r  <= SEED_EFF;
            idx_r   <= 16'd0;
            a_r     <= '0;
            b_r     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 16'd0;
            err_r   <= 16'd0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_DRIVE) || (state_s == ST_SAMPLE);
            done_r  <= (state_s == ST_DONE);
            if (start_ok_s) begin
                lfsr_r <= SEED_EFF;
                idx_r  <= 16'd0;
                pass_r <= 16'd0;
                err_r  <= 16'd0;
                a_r    <= SEED_EFF[WIDTH-1:0];
                b_r    <= SEED_EFF[2*WIDTH-1:WIDTH];
            end else if (state_r == ST_SAMPLE) begin
                lfsr_r <= lfsr_adv_s;
                idx_r  <= idx_r + 16'd1;
                if (match_s) begin
                    if (pass_r != 16'hFFFF) begin
                        pass_r <= pass_r + 16'd1;
                    end
                end else begin
                    if (err_r != 16'hFFFF) begin
                        err_r <= err_r + 16'd1;
                    end
                end
                // Operands for the next vector are loaded as DRIVE is entered.
                if (state_s == ST_DRIVE) begin
                    a_r <= lfsr_adv_s[WIDTH-1:0];
                    b_r <= lfsr_adv_s[2*WIDTH-1:WIDTH];
                end
            end
        end
    end

`ifdef MULT_CHK_FAILCAP_EN
    logic [FAIL_W-1:0] fail_r;
    logic              fail_seen_r;

    // First mismatch of a run is latched and held until start or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fail_r      <= '0;
            fail_seen_r <= 1'b0;
        end else if (start_ok_s) begin
            fail_r      <= '0;
            fail_seen_r <= 1'b0;
        end else if ((state_r == ST_SAMPLE) && !match_s && !fail_seen_r) begin
            fail_r      <= {idx_r, a_r, b_r, P};
            fail_seen_r <= 1'b1;
        end
    end

    assign fail_info = fail_r;
`else
    assign fail_info = {FAIL_W{1'b0}};
`endif

    assign A          = a_r;
    assign B          = b_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass_count = pass_r;
    assign err_count  = err_r;

endmodule

// File: tb/tb_mult_stim_checker.sv
// Randomized self-checking bench for mult_stim_checker against a timeline model of a run.
module tb_mult_stim_checker;

    localparam int NV = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  a, b;
    logic [3:0]  p;
    logic        busy, done;
    logic [15:0] pass_count, err_count;
    logic [23:0] fail_info;

    logic        tie_f = 1'b0;
    logic [3:0]  mask  = 4'h0;

    logic        rst1 = 1'b0;
    logic        start1 = 1'b0;
    logic [1:0]  a1, b1;
    logic [3:0]  p1;
    logic        busy1, done1;
    logic [15:0] pass1, err1;
    logic [23:0] fail1;

    int checks = 0;
    int errors = 0;

    logic [15:0] vec_lfsr [0:NV-1];

    always #5 clk = ~clk;

    assign p  = tie_f ? 4'hF : (({2'b00, a} * {2'b00, b}) ^ mask);
    assign p1 = {2'b00, a1} * {2'b00, b1};

    mult_stim_checker #(.WIDTH(2), .NUM_VECTORS(NV), .SEED(16'hACE1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .P(p),
        .busy(busy), .done(done), .pass_count(pass_count), .err_count(err_count),
        .fail_info(fail_info)
    );

    mult_stim_checker #(.WIDTH(2), .NUM_VECTORS(1), .SEED(16'h0000)) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1), .A(a1), .B(b1), .P(p1),
        .busy(busy1), .done(done1), .pass_count(pass1), .err_count(err1),
        .fail_info(fail1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // Behavioural model: mt counts edges since the accepting edge (-1 = idle after reset).
    int          mt = -1;
    bit          known = 1'b0;
    int          mpass = 0, merr = 0;
    logic [23:0] mfail = 24'h0;
    bit          mhas_fail = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mt = -1; mpass = 0; merr = 0; mfail = 24'h0; mhas_fail = 1'b0; known = 1'b1;
            end else if (known) begin
                if ((mt < 0 || mt == 2*NV) && start) begin
                    mt = 0; mpass = 0; merr = 0; mfail = 24'h0; mhas_fail = 1'b0;
                end else if (mt >= 0 && mt < 2*NV) begin
                    if (mt % 2 == 1) begin
                        int v;
                        logic [1:0] ea, eb;
                        logic [3:0] prod, papp;
                        v    = mt / 2;
                        ea   = vec_lfsr[v][1:0];
                        eb   = vec_lfsr[v][3:2];
                        prod = {2'b00, ea} * {2'b00, eb};
                        papp = tie_f ? 4'hF : (prod ^ mask);
                        if (papp == prod) begin
                            if (mpass < 65535) mpass++;
                        end else begin
                            if (merr < 65535) merr++;
                            if (!mhas_fail) begin
                                mfail = {v[15:0], ea, eb, papp};
                                mhas_fail = 1'b1;
                            end
                        end
                    end
                    mt++;
                end
            end
            if (known) begin
                chk("busy", 64'(busy), 64'(mt >= 0 && mt < 2*NV));
                chk("done", 64'(done), 64'(mt == 2*NV));
                chk("pass_count", 64'(pass_count), 64'(mpass));
                chk("err_count", 64'(err_count), 64'(merr));
`ifdef MULT_CHK_FAILCAP_EN
                chk("fail_info", 64'(fail_info), 64'(mfail));
`else
                chk("fail_info", 64'(fail_info), 64'h0);
`endif
                if (mt < 0) begin
                    chk("A_idle", 64'(a), 64'h0);
                    chk("B_idle", 64'(b), 64'h0);
                end else if (mt < 2*NV) begin
                    chk("A", 64'(a), 64'(vec_lfsr[mt/2][1:0]));
                    chk("B", 64'(b), 64'(vec_lfsr[mt/2][3:2]));
                end
            end
        end
    end

    task automatic run_to_done(input string name, output int edges);
        edges = 0;
        while (!done && edges < 100) begin
            cyc();
            edges++;
        end
        chk({name, "_done_edges"}, 64'(edges), 64'd40);
    endtask

    initial begin
        int edges;
        int ndone;
        logic [15:0] s;

        s = 16'hACE1;
        for (int i = 0; i < NV; i++) begin
            vec_lfsr[i] = s;
            s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
        end
        chk("model_v0", 64'(vec_lfsr[0]), 64'hACE1);
        chk("model_v1", 64'(vec_lfsr[1]), 64'hE270);
        chk("model_v2", 64'(vec_lfsr[2]), 64'h7138);

        rst = 1'b1; rst1 = 1'b1;
        repeat (3) cyc();
        rst = 1'b0; rst1 = 1'b0;
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_pass", 64'(pass_count), 64'h0);

        // NUM_VECTORS=1, zero seed falls back to ACE1.
        start1 = 1'b1;
        cyc();
        start1 = 1'b0;
        chk("n1_A", 64'(a1), 64'h1);
        chk("n1_busy", 64'(busy1), 64'h1);
        cyc();
        chk("n1_done_early", 64'(done1), 64'h0);
        cyc();
        chk("n1_done", 64'(done1), 64'h1);
        chk("n1_pass", 64'(pass1), 64'h1);
        chk("n1_err", 64'(err1), 64'h0);

        // Correct multiplier run.
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("s37_A", 64'(a), 64'h1);
        chk("s37_B", 64'(b), 64'h0);
        run_to_done("s37", edges);
        chk("s37_pass", 64'(pass_count), 64'd20);
        chk("s37_err", 64'(err_count), 64'd0);
        repeat (3) cyc();
        chk("s37_hold", 64'(pass_count), 64'd20);

        // Product stuck at 4'hF.
        tie_f = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        run_to_done("s38", edges);
        chk("s38_err", 64'(err_count), 64'd20);
        chk("s38_pass", 64'(pass_count), 64'd0);
`ifdef MULT_CHK_FAILCAP_EN
        chk("s38_fail_info", 64'(fail_info), 64'h00004F);
`endif
        tie_f = 1'b0;

        // Start re-pulsed mid-run is ignored.
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        edges = 5;
        while (!done && edges < 100) begin
            cyc();
            edges++;
        end
        chk("s39_done_edges", 64'(edges), 64'd40);
        chk("s39_pass", 64'(pass_count), 64'd20);
        chk("s39_err", 64'(err_count), 64'd0);

        // Reset at cycle 12 aborts the run.
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (12) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("s40_busy", 64'(busy), 64'h0);
        chk("s40_done", 64'(done), 64'h0);
        chk("s40_A", 64'(a), 64'h0);
        chk("s40_cnt", 64'({pass_count, err_count}), 64'h0);
        chk("s40_fail", 64'(fail_info), 64'h0);
        repeat (50) begin
            cyc();
            chk("s40_no_done", 64'(done), 64'h0);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("s40_restart_A", 64'(a), 64'h1);
        run_to_done("s40", edges);
        chk("s40_pass", 64'(pass_count), 64'd20);
        chk("s40_err", 64'(err_count), 64'd0);

        // Start held high: back-to-back runs.
        start = 1'b1;
        ndone = 0;
        repeat (130) begin
            cyc();
            if (done) begin
                ndone++;
                chk("s42_pass", 64'(pass_count), 64'd20);
            end
        end
        start = 1'b0;
        chk("s42_runs", 64'(ndone >= 3), 64'h1);

        // Randomized starts, reset and product corruption.
        repeat (1500) begin
            int r;
            r     = $urandom_range(0, 199);
            start = (r < 12);
            rst   = (r == 199);
            mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            cyc();
        end
        start = 1'b0; rst = 1'b0; mask = 4'h0;
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
